// File: rtl/traffic_ctrl_pkg.sv
// Shared light codes, phase/mode encodings and duration helpers for the
// two-road traffic-light controller.
package traffic_ctrl_pkg;

  localparam logic [1:0] LT_RED = 2'b00;
  localparam logic [1:0] LT_YEL = 2'b01;
  localparam logic [1:0] LT_GRN = 2'b11;

  localparam logic [6:0] DUR_MIN = 7'd1;
  localparam logic [6:0] DUR_MAX = 7'd99;

  typedef enum logic [1:0] {
    AG = 2'd0,
    AY = 2'd1,
    BG = 2'd2,
    BY = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    SET_G  = 2'd1,
    SET_Y  = 2'd2
  } mode_e;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      AG:      return AY;
      AY:      return BG;
      BG:      return BY;
      default: return AG;
    endcase
  endfunction

  // Edited durations wrap from the top of the range back to the bottom.
  function automatic logic [6:0] dur_inc(input logic [6:0] d);
    return (d >= DUR_MAX) ? DUR_MIN : d + 7'd1;
  endfunction

endpackage

// File: rtl/traffic_ctrl_tick_gen.sv
// Seconds prescaler: free-running 0..TICK_DIV-1 counter with a full-second
// tick and a half-second strobe for the set-mode blink.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic half
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] MID  = CW'(TICK_DIV / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
  assign half = (cnt_q == MID) || (cnt_q == LAST);

endmodule

// File: rtl/traffic_ctrl.sv
// Two-road traffic-light controller with a set mode for editing the green
// and yellow durations.
//   mode   | meaning
//   NORMAL | phases AG->AY->BG->BY advance on seconds ticks
//   SET_G  | phase frozen, inc_p edits green duration, en blinks
//   SET_Y  | phase frozen, inc_p edits yellow duration, en blinks
module traffic_ctrl
  import traffic_ctrl_pkg::*;
#(
  parameter int         TICK_DIV = 50000000,
  parameter logic [6:0] G_DEF    = 7'd9,
  parameter logic [6:0] Y_DEF    = 7'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_p,
  input  logic       inc_p,
  output logic [1:0] light_a,
  output logic [1:0] light_b,
  output logic [1:0] set_light,
  output logic       en_set,
  output logic       en,
  output logic [6:0] remain
);

  mode_e      mode_q, mode_d;
  phase_e     phase_q, phase_d;
  logic [6:0] rem_q, rem_d, g_q, g_d, y_q, y_d;
  logic       en_q, en_d, clr, tick, half;
  logic [1:0] la_q, la_d, lb_q, lb_d, sl_q, sl_d;
  logic       es_q, es_d;
  logic [6:0] remain_q, remain_d;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick),
    .half  (half)
  );

  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    g_d     = g_q;
    y_d     = y_q;
    en_d    = en_q;
    clr     = 1'b0;
    case (mode_q)
      NORMAL: begin
        if (mode_p) begin
          mode_d = SET_G;
          en_d   = 1'b1;
        end else if (tick) begin
          if (rem_q == 7'd1) begin
            phase_d = next_phase(phase_q);
            rem_d   = (phase_d == AG || phase_d == BG) ? g_q : y_q;
          end else begin
            rem_d = rem_q - 7'd1;
          end
        end
      end
      SET_G: begin
        if (mode_p) begin
          mode_d = SET_Y;
          en_d   = 1'b1;
        end else begin
          if (inc_p) g_d = dur_inc(g_q);
          if (half)  en_d = ~en_q;
        end
      end
      SET_Y: begin
        if (mode_p) begin
          // Leaving set mode restarts the cycle from a clean second boundary.
          mode_d  = NORMAL;
          phase_d = AG;
          rem_d   = g_q;
          clr     = 1'b1;
          en_d    = 1'b1;
        end else begin
          if (inc_p) y_d = dur_inc(y_q);
          if (half)  en_d = ~en_q;
        end
      end
      default: begin
        mode_d = NORMAL;
        en_d   = 1'b1;
      end
    endcase

    la_d     = (phase_d == AG) ? LT_GRN : (phase_d == AY) ? LT_YEL : LT_RED;
    lb_d     = (phase_d == BG) ? LT_GRN : (phase_d == BY) ? LT_YEL : LT_RED;
    sl_d     = (mode_d == SET_Y) ? LT_YEL : LT_GRN;
    es_d     = (mode_d != NORMAL);
    remain_d = (mode_d == SET_G) ? g_d : (mode_d == SET_Y) ? y_d : rem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= NORMAL;
      phase_q  <= AG;
      rem_q    <= G_DEF;
      g_q      <= G_DEF;
      y_q      <= Y_DEF;
      en_q     <= 1'b1;
      la_q     <= LT_GRN;
      lb_q     <= LT_RED;
      sl_q     <= LT_GRN;
      es_q     <= 1'b0;
      remain_q <= G_DEF;
    end else begin
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      rem_q    <= rem_d;
      g_q      <= g_d;
      y_q      <= y_d;
      en_q     <= en_d;
      la_q     <= la_d;
      lb_q     <= lb_d;
      sl_q     <= sl_d;
      es_q     <= es_d;
      remain_q <= remain_d;
    end
  end

  assign light_a   = la_q;
  assign light_b   = lb_q;
  assign set_light = sl_q;
  assign en_set    = es_q;
  assign en        = en_q;
  assign remain    = remain_q;

endmodule
